// File: rtl/tinyalu_pkg.sv
// Shared types for the TinyALU instruction sequencer: ALU opcodes, FSM states
// and the opcode-to-first-state decode.
package tinyalu_pkg;

    localparam int OPC_W = 4;

    typedef enum logic [OPC_W-1:0] {
        op_nop   = 4'd0,
        op_load  = 4'd1,
        op_store = 4'd2,
        op_add   = 4'd3,
        op_and   = 4'd4,
        op_xor   = 4'd5,
        op_mul   = 4'd6
    } alu_opcode_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STORE,
        EXEC,
        RETIRE
    } iu_state_t;

    // Unknown opcodes retire like a NOP so a bad instruction never hangs the unit.
    function automatic iu_state_t decode_state(input logic [OPC_W-1:0] opc);
        iu_state_t s;
        if (opc == op_load)
            s = LOAD;
        else if (opc == op_store)
            s = STORE;
        else if (opc == op_nop || opc > op_mul)
            s = RETIRE;
        else
            s = EXEC;
        return s;
    endfunction

endpackage

// File: rtl/iu_regfile.sv
// Operand register file for the instruction sequencer: one write port,
// two combinational read ports, synchronous active-low reset.
module iu_regfile #(
    parameter int DATA_W = 8,
    parameter int NREG   = 2,
    parameter int RSEL_W = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [RSEL_W-1:0] wsel,
    input  logic [DATA_W-1:0] wdata,
    input  logic [RSEL_W-1:0] rsel_a,
    input  logic [RSEL_W-1:0] rsel_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];

    always_comb begin
        regs_d = regs_q;
        if (we)
            regs_d[wsel] = wdata;
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            regs_q <= '{default: '0};
        else
            regs_q <= regs_d;
    end

    assign rdata_a = regs_q[rsel_a];
    assign rdata_b = regs_q[rsel_b];

endmodule

// File: rtl/instr_sequencer.sv
// TinyALU instruction sequencer: accepts one instruction, runs it against the
// memory unit or ALU and pulses done on retire. Optional watchdog: IU_TIMEOUT_EN.
module instr_sequencer
    import tinyalu_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 14,
    parameter int NREG    = 2,
    parameter int TIMEOUT = 255,
    localparam int RSEL_W = $clog2(NREG),
    localparam int INSTR_W = OPC_W + ADDR_W + RSEL_W
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                instr_valid,
    input  logic [INSTR_W-1:0]  instr,
    output logic                instr_ready,
    output logic                load,
    output logic                store,
    output logic [ADDR_W-1:0]   addr,
    output logic [2*DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_done,
    output logic                start,
    output logic [OPC_W-1:0]    op,
    output logic [DATA_W-1:0]   A,
    output logic [DATA_W-1:0]   B,
    input  logic [2*DATA_W-1:0] alu_result,
    input  logic                alu_done,
    output logic                done,
    output logic                busy,
    output logic                err
);

    iu_state_t           state_q, state_d;
    logic                acc_q, acc_d;
    logic [OPC_W-1:0]    opc_q, opc_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [RSEL_W-1:0]   rsel_q, rsel_d;
    logic [2*DATA_W-1:0] last_q, last_d;
    logic                ready_q, ready_d, busy_q, busy_d, done_q, done_d;
    logic                load_q, load_d, store_q, store_d, start_q, start_d;
    logic                err_q, err_d;
    logic                accept, reg_we, timeout;
    logic [RSEL_W-1:0]   rsel_b;

`ifdef IU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        timeout = (state_q inside {LOAD, STORE, EXEC}) && (cnt_q == CNT_W'(TIMEOUT - 1));
        cnt_d   = '0;
        if (state_d == state_q && (state_q inside {LOAD, STORE, EXEC}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |32'(TIMEOUT);
    assign timeout = 1'b0;
`endif

    // An accepted instruction spends one cycle latched in IDLE before decode.
    always_comb begin
        state_d = state_q;
        acc_d   = 1'b0;
        opc_d   = opc_q;
        addr_d  = addr_q;
        rsel_d  = rsel_q;
        last_d  = last_q;
        err_d   = err_q;
        reg_we  = 1'b0;
        accept  = instr_valid && ready_q;
        case (state_q)
            IDLE: begin
                if (acc_q) begin
                    state_d = decode_state(opc_q);
                end else if (accept) begin
                    acc_d = 1'b1;
                    {opc_d, addr_d, rsel_d} = instr;
                end
            end
            LOAD: begin
                if (mem_done) begin
                    reg_we  = 1'b1;
                    state_d = RETIRE;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = RETIRE;
                end
            end
            STORE: begin
                if (mem_done) begin
                    state_d = RETIRE;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = RETIRE;
                end
            end
            EXEC: begin
                if (alu_done) begin
                    last_d  = alu_result;
                    state_d = RETIRE;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = RETIRE;
                end
            end
            RETIRE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE) && !acc_d;
        busy_d  = !ready_d;
        load_d  = (state_d == LOAD);
        store_d = (state_d == STORE);
        start_d = (state_d == EXEC);
        done_d  = (state_d == RETIRE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            acc_q   <= 1'b0;
            opc_q   <= op_nop;
            addr_q  <= '0;
            rsel_q  <= '0;
            last_q  <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            load_q  <= 1'b0;
            store_q <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            opc_q   <= opc_d;
            addr_q  <= addr_d;
            rsel_q  <= rsel_d;
            last_q  <= last_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            load_q  <= load_d;
            store_q <= store_d;
            start_q <= start_d;
            done_q  <= done_d;
        end
    end

    assign rsel_b = rsel_q + 1'b1;

    iu_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG),
        .RSEL_W (RSEL_W)
    ) u_regfile (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (reg_we),
        .wsel    (rsel_q),
        .wdata   (mem_rdata),
        .rsel_a  (rsel_q),
        .rsel_b  (rsel_b),
        .rdata_a (A),
        .rdata_b (B)
    );

    assign instr_ready = ready_q;
    assign busy        = busy_q;
    assign load        = load_q;
    assign store       = store_q;
    assign start       = start_q;
    assign done        = done_q;
    assign err         = err_q;
    assign addr        = addr_q;
    assign op          = opc_q;
    assign wdata       = last_q;

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Parametrised, fully registered instruction sequencer for the TinyALU test system. It accepts one instruction at a time over a valid/ready handshake and decodes it. It then runs a load, store or ALU operation against the memory interface unit and the ALU593, using level handshakes held until done. A single-cycle done pulse marks retirement. It sits between the instruction source and the ALU / memory interface.

Parameters:
DATA_W, 8, operand/register width; ALU result width is 2*DATA_W
ADDR_W, 14, main-memory address width
NREG, 2, operand registers (power of 2, >=2); RSEL_W = $clog2(NREG)
TIMEOUT, 255, watchdog limit in cycles (used only with IU_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  reset
instr_valid  in  1  instruction offered
instr  in  4+ADDR_W+RSEL_W  {opcode[4], addr[ADDR_W], rsel[RSEL_W]}
instr_ready  out  1  sequencer can accept
load  out  1  memory read request, held until mem_done
store  out  1  memory write request, held until mem_done
addr  out  ADDR_W  memory address
wdata  out  2*DATA_W  store data (last ALU result)
mem_rdata  in  DATA_W  load data, valid with mem_done
mem_done  in  1  memory op complete
start  out  1  ALU start, held until alu_done
op  out  4  alu_opcode_t to ALU
A, B  out  DATA_W  ALU operands
alu_result  in  2*DATA_W  ALU result, valid with alu_done
alu_done  in  1  ALU op complete
done  out  1  one-cycle retire pulse
busy  out  1  state != IDLE
err  out  1  sticky watchdog error (IU_TIMEOUT_EN only)

Behaviour:
- reset_n: synchronous, active-low. It overrides everything, including a reset mid-operation, and returns the FSM to IDLE.
- Reset values: load=store=start=done=busy=err=0; instr_ready=1; addr=0; op=op_nop; all regs=0; last_result=0.
- All outputs are registered. instr_ready = (state==IDLE). Accept when instr_valid && instr_ready; opcode, addr and rsel are latched on accept.
- FSM IDLE -> (accept) LOAD | STORE | EXEC | RETIRE.
  - opcode==op_load -> LOAD.
  - opcode==op_store -> STORE.
  - op_nop or an opcode outside alu_opcode_t -> RETIRE.
  - Any other opcode -> EXEC.
- LOAD: load=1 and addr=latched addr from the cycle after accept. On mem_done: reg[rsel] <= mem_rdata, load drops next cycle, go to RETIRE.
- STORE: store=1, addr valid, wdata=last_result. On mem_done go to RETIRE.
- EXEC: start=1 and op=latched opcode from the cycle after accept.
  - A=reg[rsel], B=reg[(rsel+1) mod NREG].
  - On alu_done: last_result <= alu_result, start drops next cycle, go to RETIRE.
- RETIRE: done=1 for exactly one cycle, then IDLE. instr_ready rises on the cycle after done.
- Minimum latency, accept to done:
  - NOP: 2 cycles.
  - Memory/ALU ops: 3 cycles when mem_done/alu_done arrives on the first request cycle.
- mem_done or alu_done outside its matching state is ignored, with no register update. Both asserted together: only the one matching the state is honoured.
- A and B are continuously driven from reg[rsel] and reg[rsel+1] of the latched instruction. Register updates occur only in LOAD.
- last_result persists across instructions until the next ALU completion. wdata always equals last_result.
- The rsel index wraps modulo NREG.

Optional Feature:
IU_TIMEOUT_EN.
- Defined: a cycle counter runs in LOAD, STORE and EXEC and clears on state entry.
- When the counter reaches TIMEOUT without the matching done:
  - drop load/store/start;
  - set sticky err=1;
  - go to RETIRE, with no register or last_result update.
- err clears only on reset.
- Undefined: no counter; the FSM waits indefinitely; err is tied to 0.

Decomposition:
- tinyalu_pkg: alu_opcode_t (op_nop=0, op_load, op_store), instruction field-width localparams, and the iu_state_t enum (IDLE, LOAD, STORE, EXEC, RETIRE).
- One natural sub-module: iu_regfile (NREG x DATA_W, one write port, two read ports).

Test Plan:
- Reset mid-EXEC (start=1): reset_n=0 one cycle -> next cycle start=0, instr_ready=1, A=B=0, busy=0.
- load rsel0 addr 0x0010, mem_rdata=0x12; load rsel1 addr 0x0011, mem_rdata=0x34 -> regs 0x12/0x34, load high until each mem_done, addr=0x0010 then 0x0011, one done pulse each.
- ALU add opcode with regs 0x12/0x34; alu_done after 1 cycle, alu_result=0x0046 -> A=0x12, B=0x34, start held until done, done pulse, last_result=0x0046.
- Store to 0x3FFF -> store=1, addr=0x3FFF, wdata=0x0046 until mem_done; spurious alu_done during STORE ignored.
- Back-to-back: instr_valid held high for NOP, NOP -> done at T+2, instr_ready at T+3, second NOP done at T+5.
- With IU_TIMEOUT_EN, TIMEOUT=4, load with no mem_done -> load drops after 4 cycles, err=1, done pulse, target reg unchanged.
